// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the run-control sequencer
package rv_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;
  typedef enum logic [2:0] {
    HC_NONE     = 3'd0,
    HC_EXT      = 3'd1,
    HC_STEP     = 3'd2,
    HC_BP       = 3'd3,
    HC_ECALL    = 3'd4,
    HC_EBREAK   = 3'd5,
    HC_MISALIGN = 3'd6
  } cause_e;
  localparam logic [31:0] ECALL_OP  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_OP = 32'h0010_0073;
  localparam int unsigned PC_INC    = 4;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-PC candidate (jump over branch over sequential)
module next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] cand,
  output logic            misaligned
);
  import rv_ctrl_pkg::*;
  always_comb begin
    cand       = jump ? jump_target : branch_taken ? branch_target : pc + XLEN'(PC_INC);
    misaligned = |cand[1:0];
  end
endmodule

// File: rtl/pc_run_controller.sv
// pc_run_controller: run/step/halt sequencer owning the core's fetch PC and retire counter
module pc_run_controller
  import rv_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             restart,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  input  logic [XLEN-1:0]  instruction,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  output logic [XLEN-1:0]  pc_next,
  output logic             exec_en,
  output logic [1:0]       state,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] retire_cnt
);
  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic [XLEN-1:0]   pc_q, pc_d, cand;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              misaligned;

  next_pc_sel #(.XLEN(XLEN)) u_sel (
    .pc           (pc_q),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .cand         (cand),
    .misaligned   (misaligned)
  );

  assign exec_en    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign pc_next    = pc_q;
  assign state      = state_q;
  assign halt_cause = cause_q;
  assign retire_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = ST_IDLE;
      cause_d = HC_NONE;
      pc_d    = RESET_PC;
      cnt_d   = '0;
    end else if (exec_en) begin
      // traps leave the PC on the offending instruction and do not retire
      if (instruction == ECALL_OP) begin
        state_d = ST_HALTED;
        cause_d = HC_ECALL;
      end else if (instruction == EBREAK_OP) begin
        state_d = ST_HALTED;
        cause_d = HC_EBREAK;
      end else if (misaligned) begin
        state_d = ST_HALTED;
        cause_d = HC_MISALIGN;
      end else begin
        pc_d  = cand;
        cnt_d = cnt_q + 1'b1;
        if (bp_en && cand == bp_addr) begin
          state_d = ST_HALTED;
          cause_d = HC_BP;
        end else if (state_q == ST_STEP) begin
          state_d = ST_HALTED;
          cause_d = HC_STEP;
        end else if (halt_req) begin
          state_d = ST_HALTED;
          cause_d = HC_EXT;
        end
      end
    end else if (step || start) begin
      state_d = step ? ST_STEP : ST_RUN;
      cause_d = HC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= HC_NONE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pc_run_controller.sv
// tb_pc_run_controller: directed scenarios plus random run against a reference model
module tb_pc_run_controller;
  logic        clk = 1'b0;
  logic        rst, start, step, halt_req, restart, bp_en, branch_taken, jump;
  logic [31:0] bp_addr, instruction, branch_target, jump_target;
  logic [31:0] pc_next, retire_cnt;
  logic        exec_en;
  logic [1:0]  state;
  logic [2:0]  halt_cause;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc, m_cnt;
  int          m_st, m_hc;

  always #5 clk = ~clk;

  pc_run_controller dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
    .restart(restart), .bp_en(bp_en), .bp_addr(bp_addr), .instruction(instruction),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .pc_next(pc_next), .exec_en(exec_en), .state(state),
    .halt_cause(halt_cause), .retire_cnt(retire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    {rst, start, step, halt_req, restart, bp_en, branch_taken, jump} = '0;
    bp_addr = 0; branch_target = 0; jump_target = 0; instruction = 32'h0000_0013;
  endtask

  // Reference: states/causes as plain ints, one instruction per executing cycle.
  task automatic model();
    logic [31:0] tgt;
    tgt = jump ? jump_target : branch_taken ? branch_target : m_pc + 32'd4;
    if (rst || restart) begin
      m_pc = 0; m_cnt = 0; m_st = 0; m_hc = 0;
    end else if (m_st == 1 || m_st == 2) begin
      if (instruction == 32'h0000_0073) begin m_st = 3; m_hc = 4; end
      else if (instruction == 32'h0010_0073) begin m_st = 3; m_hc = 5; end
      else if (tgt % 4 != 0) begin m_st = 3; m_hc = 6; end
      else begin
        m_pc = tgt; m_cnt = m_cnt + 1;
        if (bp_en && tgt == bp_addr) begin m_st = 3; m_hc = 3; end
        else if (m_st == 2) begin m_st = 3; m_hc = 2; end
        else if (halt_req) begin m_st = 3; m_hc = 1; end
      end
    end else if (step) begin m_st = 2; m_hc = 0; end
    else if (start) begin m_st = 1; m_hc = 0; end
  endtask

  task automatic tick();
    model();
    @(posedge clk);
    #1;
    check("pc_next", pc_next, m_pc);
    check("retire_cnt", retire_cnt, m_cnt);
    check("state", 32'(state), 32'(m_st));
    check("halt_cause", 32'(halt_cause), 32'(m_hc));
    check("exec_en", 32'(exec_en), 32'(m_st == 1 || m_st == 2));
    idle_inputs();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
  endtask

  initial begin
    m_pc = 32'hx; m_cnt = 32'hx; m_st = 0; m_hc = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    check("rst_pc", pc_next, 32'h0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_exec", 32'(exec_en), 32'd0);
    // T1 straight-line
    start = 1'b1; tick();
    check("t1_run", 32'(state), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t1_pc", pc_next, 32'(4 * i));
    end
    check("t1_cnt", retire_cnt, 32'd4);
    // T2 jump wins over branch
    jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    check("t2_pc", pc_next, 32'h40);
    check("t2_state", 32'(state), 32'd1);
    // T3 breakpoint, then resume executes bp_addr
    do_restart();
    start = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin bp_en = 1'b1; bp_addr = 32'h14; tick(); end
    check("t3_cause", 32'(halt_cause), 32'd3);
    check("t3_pc", pc_next, 32'h14);
    check("t3_cnt", retire_cnt, 32'd5);
    bp_en = 1'b1; bp_addr = 32'h14; start = 1'b1; tick();
    bp_en = 1'b1; bp_addr = 32'h14; tick();
    check("t3_resume_pc", pc_next, 32'h18);
    check("t3_resume_state", 32'(state), 32'd1);
    // T4 three single steps
    do_restart();
    for (int i = 0; i < 3; i++) begin step = 1'b1; tick(); tick(); end
    check("t4_pc", pc_next, 32'h0C);
    check("t4_cnt", retire_cnt, 32'd3);
    check("t4_cause", 32'(halt_cause), 32'd2);
    // T5 EBREAK at 0x08 stays trapped on resume
    do_restart();
    start = 1'b1; tick();
    tick(); tick();
    instruction = 32'h0010_0073; tick();
    check("t5_cause", 32'(halt_cause), 32'd5);
    check("t5_pc", pc_next, 32'h08);
    check("t5_cnt", retire_cnt, 32'd2);
    start = 1'b1; tick();
    instruction = 32'h0010_0073; tick();
    check("t5_retrap", 32'(halt_cause), 32'd5);
    do_restart();
    check("t5_restart_pc", pc_next, 32'h0);
    check("t5_restart_cnt", retire_cnt, 32'd0);
    // T6 misaligned target, BP beats halt_req, rst mid-run
    start = 1'b1; tick();
    branch_taken = 1'b1; branch_target = 32'h22; tick();
    check("t6_mis", 32'(halt_cause), 32'd6);
    check("t6_mis_pc", pc_next, 32'h0);
    do_restart();
    start = 1'b1; tick();
    bp_en = 1'b1; bp_addr = 32'h4; halt_req = 1'b1; tick();
    check("t6_bp_prio", 32'(halt_cause), 32'd3);
    start = 1'b1; tick();
    tick();
    rst = 1'b1; tick();
    check("t6_rst_pc", pc_next, 32'h0);
    check("t6_rst_cnt", retire_cnt, 32'd0);
    check("t6_rst_state", 32'(state), 32'd0);
    // Random run
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] t;
      start    = ($urandom_range(0, 3) == 0);
      step     = ($urandom_range(0, 5) == 0);
      halt_req = ($urandom_range(0, 9) == 0);
      restart  = ($urandom_range(0, 60) == 0);
      rst      = ($urandom_range(0, 150) == 0);
      jump     = ($urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      t = $urandom & 32'h0000_00FF;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      jump_target = t;
      t = $urandom & 32'h0000_00FF;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      branch_target = t;
      bp_en   = ($urandom_range(0, 1) == 0);
      bp_addr = ($urandom_range(0, 1) == 0) ? m_pc + 32'd4 : ($urandom & 32'hFC);
      case ($urandom_range(0, 19))
        0:       instruction = 32'h0000_0073;
        1:       instruction = 32'h0010_0073;
        default: instruction = $urandom;
      endcase
      if (instruction == 32'h0000_0073 || instruction == 32'h0010_0073)
        if ($urandom_range(0, 3) != 0) instruction = 32'h13;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
